// File: rtl/uart_rx_oversampler_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampler_pkg
//   Shared definitions for the oversampling UART receiver: FSM state
//   encoding and the fixed tick positions inside one 16x-oversampled bit.
// ---------------------------------------------------------------------------
package uart_rx_oversampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Tick index of the middle of the start bit, and the last tick of a
    // full bit period (16 ticks per bit).
    localparam int MID_TICK  = 7;
    localparam int LAST_TICK = 15;

endpackage

// File: rtl/uart_rx_oversampler_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   SYNC_STG-flop synchroniser for the asynchronous serial line. Resets to 1
//   so that a reset never looks like a start bit.
// Ports:
//   i_clk    in  1  system clock
//   i_reset  in  1  synchronous, active-low reset
//   i_rx     in  1  asynchronous serial input
//   o_rx_s   out 1  synchronised serial line (SYNC_STG clocks of latency)
// ---------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_rx_s
);

    if (SYNC_STG < 2) begin : g_bad_sync_stg
        $error("SYNC_STG must be at least 2");
    end

    logic [SYNC_STG-1:0] sync_q;

    // Shift chain; the oldest stage is the synchronised output.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], i_rx};
        end
    end

    assign o_rx_s = sync_q[SYNC_STG-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampler
//   Oversampling UART receiver front-end. Samples the serial line on 16x-baud
//   ticks, assembles DBIT data bits LSB first and strobes the received word,
//   a framing-error flag and (optionally) a parity-error flag for one cycle.
//
//   Optional feature: define UART_RX_PARITY_EN to add a parity bit between
//   the data bits and the stop bit(s). Without it o_parity_err is always 0.
//
// Ports:
//   i_clk           in   1     system clock
//   i_reset         in   1     synchronous, active-low reset
//   i_s_tick        in   1     16x-baud enable pulse, one i_clk wide
//   i_rx            in   1     asynchronous serial line, idle high
//   o_dout          out  DBIT  received word, held until the next frame
//   o_rx_done_tick  out  1     one-cycle strobe: frame complete
//   o_frame_err     out  1     stop bit sampled 0 (valid with done tick)
//   o_parity_err    out  1     parity mismatch (valid with done tick)
//   o_busy          out  1     receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_oversampler
    import uart_rx_oversampler_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int SYNC_STG   = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_s_tick,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done_tick,
    output logic            o_frame_err,
    output logic            o_parity_err,
    output logic            o_busy
);

    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("PARITY_ODD must be 0 or 1");
    end

    // The tick counter is 4 bits for a 16-tick bit; it widens only when the
    // stop period (1.5 or 2 stop bits) needs more than 16 ticks.
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] MID_CNT  = SW'(MID_TICK);
    localparam logic [SW-1:0] LAST_CNT = SW'(LAST_TICK);
    localparam logic [SW-1:0] STOP_CNT = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

    logic rx_s;

    uart_rx_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_rx    (i_rx),
        .o_rx_s  (rx_s)
    );

    rx_state_t       state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            frame_err_q, frame_err_d;
    logic            parity_err_q, parity_err_d;
    logic            break_hold_q, break_hold_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
`endif

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            s_cnt_q      <= '0;
            n_cnt_q      <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_hold_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s_cnt_q      <= s_cnt_d;
            n_cnt_q      <= n_cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_hold_q <= break_hold_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
`endif
        end
    end

    // Next-state and datapath logic. A stop bit sampled low sets break_hold,
    // so a line stuck low produces exactly one frame and no restart until
    // the line has been seen idle again.
    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        n_cnt_d      = n_cnt_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        done_d       = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        break_hold_d = break_hold_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rx_s) begin
                    break_hold_d = 1'b0;
                end else if (!break_hold_q) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                end
            end

            ST_START: begin
                if (i_s_tick) begin
                    if (s_cnt_q == MID_CNT) begin
                        s_cnt_d = '0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            n_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (i_s_tick) begin
                    if (s_cnt_q == LAST_CNT) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (i_s_tick) begin
                    if (s_cnt_q == LAST_CNT) begin
                        s_cnt_d   = '0;
                        par_bit_d = rx_s;
                        state_d   = ST_STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`endif

            ST_STOP: begin
                if (i_s_tick) begin
                    if (s_cnt_q == STOP_CNT) begin
                        s_cnt_d      = '0;
                        state_d      = ST_IDLE;
                        dout_d       = shreg_q;
                        frame_err_d  = ~rx_s;
                        break_hold_d = ~rx_s;
                        done_d       = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bit_q != ((^shreg_q) ^ 1'(PARITY_ODD));
`else
                        parity_err_d = 1'b0;
`endif
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                s_cnt_d = '0;
            end
        endcase
    end

    assign o_dout         = dout_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_err    = frame_err_q;
    assign o_parity_err   = parity_err_q;
    assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_oversampler
//   Drives serial frames into uart_rx_oversampler and checks every cycle
//   against a frame-level reference model: each frame sent queues the word
//   and error flags the receiver must report; outputs must hold between
//   strobes and no strobe may appear without a queued frame.
//   Honours UART_RX_PARITY_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_uart_rx_oversampler;

    localparam int DBIT       = 8;
    localparam int SB_TICK    = 16;
    localparam int SYNC_STG   = 2;
    localparam int PARITY_ODD = 0;
    localparam int TICK_DIV   = 16;
    localparam int BIT_CLKS   = TICK_DIV * 16;

    logic            i_clk    = 1'b0;
    logic            i_reset  = 1'b0;
    logic            i_s_tick = 1'b0;
    logic            i_rx     = 1'b1;
    logic [DBIT-1:0] o_dout;
    logic            o_rx_done_tick;
    logic            o_frame_err;
    logic            o_parity_err;
    logic            o_busy;

    uart_rx_oversampler #(
        .DBIT       (DBIT),
        .SB_TICK    (SB_TICK),
        .SYNC_STG   (SYNC_STG),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_s_tick       (i_s_tick),
        .i_rx           (i_rx),
        .o_dout         (o_dout),
        .o_rx_done_tick (o_rx_done_tick),
        .o_frame_err    (o_frame_err),
        .o_parity_err   (o_parity_err),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Baud generator stand-in: one-clock tick every TICK_DIV clocks.
    int tick_div_cnt = 0;
    always @(negedge i_clk) begin
        tick_div_cnt = (tick_div_cnt + 1) % TICK_DIV;
        i_s_tick     = (tick_div_cnt == 0);
    end

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } frame_t;

    frame_t     exp_q[$];
    frame_t     cur_exp;
    logic [7:0] held_dout = '0;
    logic       held_fe   = 1'b0;
    logic       held_pe   = 1'b0;
    int         compared   = 0;
    int         mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Parity bit a correct transmitter would send for this byte.
    function automatic logic good_par(input logic [7:0] data);
        return logic'(($countones(data) % 2) ^ PARITY_ODD);
    endfunction

    // Model of the parity flag: total ones (data + parity bit) must have the
    // configured oddness; without the option the flag is always 0.
    function automatic logic exp_parity_err(input logic [7:0] data, input logic par_bit);
`ifdef UART_RX_PARITY_EN
        return logic'((($countones(data) + int'(par_bit)) % 2) != PARITY_ODD);
`else
        return 1'b0 & (data[0] | par_bit);
`endif
    endfunction

    // Per-cycle compare against the frame-level model.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            held_dout = '0;
            held_fe   = 1'b0;
            held_pe   = 1'b0;
        end else if (o_rx_done_tick) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                cur_exp = exp_q.pop_front();
                checkOutput("done_dout", 32'(o_dout), 32'(cur_exp.data));
                checkOutput("done_frame_err", 32'(o_frame_err), 32'(cur_exp.fe));
                checkOutput("done_parity_err", 32'(o_parity_err), 32'(cur_exp.pe));
                held_dout = cur_exp.data;
                held_fe   = cur_exp.fe;
                held_pe   = cur_exp.pe;
            end
        end else begin
            checkOutput("held_outputs", {o_dout, o_frame_err, o_parity_err},
                        {held_dout, held_fe, held_pe});
        end
    end

    task automatic send_bit(input logic b);
        i_rx = b;
        repeat (BIT_CLKS) @(negedge i_clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Sends one complete frame; queues its expected result when the
    // receiver is supposed to deliver it.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input logic par_bit, input bit expect_frame);
        frame_t f;
        if (expect_frame) begin
            f.data = data;
            f.fe   = ~stop_val;
            f.pe   = exp_parity_err(data, par_bit);
            exp_q.push_back(f);
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`endif
        send_bit(stop_val);
    endtask

    // The strobe falls in the middle of the stop bit, so by the end of the
    // frame every queued result must have been consumed.
    task automatic frame_delivered(input string name);
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        checkOutput(name, {o_dout, o_rx_done_tick, o_frame_err, o_parity_err, o_busy}, 32'd0);
    endtask

    initial begin
        repeat (200000) @(posedge i_clk);
        mismatched++;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    frame_t brk;
    logic [7:0] rdata;
    logic       rstop;
    logic       rpar;

    initial begin
        // Reset state
        i_reset = 1'b0;
        repeat (4) @(negedge i_clk);
        check_all_zero("reset_outputs");
        i_reset = 1'b1;
        idle_bits(2);

        // 1: clean 0xA5
        applyStimulus(8'hA5, 1'b1, good_par(8'hA5), 1'b1);
        frame_delivered("t1_delivered");
        checkOutput("t1_dout", 32'(o_dout), 32'hA5);
        checkOutput("t1_frame_err", 32'(o_frame_err), 32'd0);
        checkOutput("t1_busy", 32'(o_busy), 32'd0);
        idle_bits(1);

        // 2: start glitch of 3 ticks
        i_rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge i_clk);
        checkOutput("t2_busy_during_glitch", 32'(o_busy), 32'd1);
        i_rx = 1'b1;
        repeat (16 * TICK_DIV) @(negedge i_clk);
        checkOutput("t2_busy_after_glitch", 32'(o_busy), 32'd0);
        checkOutput("t2_dout_unchanged", 32'(o_dout), 32'hA5);
        idle_bits(1);

        // 3: framing error then a clean frame clears it
        applyStimulus(8'h3C, 1'b0, good_par(8'h3C), 1'b1);
        frame_delivered("t3_delivered");
        checkOutput("t3_dout", 32'(o_dout), 32'h3C);
        checkOutput("t3_frame_err", 32'(o_frame_err), 32'd1);
        idle_bits(1);
        applyStimulus(8'h01, 1'b1, good_par(8'h01), 1'b1);
        frame_delivered("t3_clean_delivered");
        checkOutput("t3_frame_err_cleared", 32'(o_frame_err), 32'd0);
        idle_bits(1);

        // 4: break for 20 bit times -> exactly one error frame
        brk.data = 8'h00;
        brk.fe   = 1'b1;
        brk.pe   = exp_parity_err(8'h00, 1'b0);
        exp_q.push_back(brk);
        i_rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge i_clk);
        frame_delivered("t4_break_delivered");
        checkOutput("t4_dout", 32'(o_dout), 32'h00);
        checkOutput("t4_frame_err", 32'(o_frame_err), 32'd1);
        checkOutput("t4_busy_in_break", 32'(o_busy), 32'd0);
        idle_bits(2);
        applyStimulus(8'h55, 1'b1, good_par(8'h55), 1'b1);
        frame_delivered("t4_after_break");
        checkOutput("t4_dout_55", 32'(o_dout), 32'h55);
        checkOutput("t4_frame_err_cleared", 32'(o_frame_err), 32'd0);
        idle_bits(1);

        // 5: reset in the middle of a 0xFF frame
        fork
            applyStimulus(8'hFF, 1'b1, good_par(8'hFF), 1'b0);
            begin
                repeat (3 * BIT_CLKS) @(negedge i_clk);
                checkOutput("t5_busy_mid_data", 32'(o_busy), 32'd1);
                i_reset = 1'b0;
                repeat (2) @(negedge i_clk);
                check_all_zero("t5_reset_outputs");
                i_reset = 1'b1;
            end
        join
        idle_bits(1);
        applyStimulus(8'h81, 1'b1, good_par(8'h81), 1'b1);
        frame_delivered("t5_after_reset");
        checkOutput("t5_dout_81", 32'(o_dout), 32'h81);
        idle_bits(1);

`ifdef UART_RX_PARITY_EN
        // 6: even parity on 0x07
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
        frame_delivered("t6_good_par_delivered");
        checkOutput("t6_parity_ok", 32'(o_parity_err), 32'd0);
        idle_bits(1);
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
        frame_delivered("t6_bad_par_delivered");
        checkOutput("t6_parity_err", 32'(o_parity_err), 32'd1);
        idle_bits(1);
`endif

        // Random frames: random data, occasional bad stop / bad parity bit
        for (int n = 0; n < 8; n++) begin
            rdata = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rpar  = good_par(rdata) ^ ($urandom_range(0, 3) == 0);
            applyStimulus(rdata, rstop, rpar, 1'b1);
            frame_delivered("rand_delivered");
            idle_bits(int'($urandom_range(1, 2)));
        end
        checkOutput("final_busy", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
